// File: rtl/fpu_add_arbiter.sv
`timescale 1ns/1ps
// Purpose : round-robin arbiter sharing one pipelined floating-point adder among N_REQ requesters.
// Latency : ADDER_LAT+2 cycles from req handshake to res_vld; one operation issued per cycle.
// Backpres: req_rdy is a one-hot combinational grant; results are never stalled and must be taken.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   req_vld/req_a/req_b      per-requester requests; requester i operands at [32i+31:32i]
//   req_rdy                  one-hot grant to the selected requester
//   add_a/add_b/add_vld      registered issue to the adder
//   add_result/add_res_state adder outputs, valid ADDER_LAT cycles after add_vld
//   res_vld                  one-hot result pulse to the originating requester
//   res_data/res_state       shared result bus, holds its value between pulses
//   busy                     high while any operation is in flight
//
// Optional build macro FPU_ADD_ARB_PERF_EN adds grant_cnt (16 bits per requester)
// and stall_cnt (16 bits) saturating performance counters.

module fpu_add_arbiter #(
  parameter int N_REQ     = 4,
  parameter int ADDER_LAT = 6,
  parameter int STATE_W   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_vld,
  input  logic [32*N_REQ-1:0]   req_a,
  input  logic [32*N_REQ-1:0]   req_b,
  output logic [N_REQ-1:0]      req_rdy,
  output logic [31:0]           add_a,
  output logic [31:0]           add_b,
  output logic                  add_vld,
  input  logic [31:0]           add_result,
  input  logic [STATE_W-1:0]    add_res_state,
  output logic [N_REQ-1:0]      res_vld,
  output logic [31:0]           res_data,
  output logic [STATE_W-1:0]    res_state,
  output logic                  busy
`ifdef FPU_ADD_ARB_PERF_EN
  ,
  output logic [16*N_REQ-1:0]   grant_cnt,
  output logic [15:0]           stall_cnt
`endif
);

  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;

  logic               add_vld_q;
  logic [31:0]        add_a_q, add_a_d;
  logic [31:0]        add_b_q, add_b_d;
  logic [IDW-1:0]     issue_id_q;

  // Tag pipe: entry k is valid in the cycle that is k+1 cycles after add_vld,
  // so the last entry lines up with the adder result.
  logic [ADDER_LAT-1:0] tag_vld_q;
  logic [IDW-1:0]       tag_id_q [ADDER_LAT];

  logic [N_REQ-1:0]   res_vld_q, res_vld_d;
  logic [31:0]        res_data_q;
  logic [STATE_W-1:0] res_state_q;

  // ---------------------------------------------------------------------------
  // Round-robin grant
  // ---------------------------------------------------------------------------
  logic             grant_any;
  logic [IDW-1:0]   grant_id;
  logic [IDW:0]     cand_sum;
  logic [IDW-1:0]   cand;

  always_comb begin
    req_rdy   = '0;
    grant_any = 1'b0;
    grant_id  = '0;
    cand_sum  = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      // rr_ptr + k wrapped into 0..N_REQ-1 (works for non-power-of-two N_REQ)
      cand_sum = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (cand_sum >= (IDW+1)'(N_REQ)) begin
        cand_sum = cand_sum - (IDW+1)'(N_REQ);
      end
      cand = cand_sum[IDW-1:0];
      if (!grant_any && req_vld[cand]) begin
        grant_any     = 1'b1;
        grant_id      = cand;
        req_rdy[cand] = 1'b1;
      end
    end
  end

  // A grant is only ever given to a valid requester, so a grant is a transfer.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_any) begin
      if (grant_id == IDW'(N_REQ - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = grant_id + IDW'(1);
      end
    end
  end

  // Operand mux driven by the one-hot grant; operands hold when nothing is issued.
  always_comb begin
    add_a_d = add_a_q;
    add_b_d = add_b_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_rdy[i]) begin
        add_a_d = req_a[32*i +: 32];
        add_b_d = req_b[32*i +: 32];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Issue stage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      add_vld_q  <= 1'b0;
      add_a_q    <= '0;
      add_b_q    <= '0;
      issue_id_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      add_vld_q  <= grant_any;
      add_a_q    <= add_a_d;
      add_b_q    <= add_b_d;
      issue_id_q <= grant_id;
    end
  end

  // ---------------------------------------------------------------------------
  // Tag pipeline
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_q <= '0;
      for (int k = 0; k < ADDER_LAT; k++) begin
        tag_id_q[k] <= '0;
      end
    end else begin
      tag_vld_q[0] <= add_vld_q;
      tag_id_q[0]  <= issue_id_q;
      for (int k = 1; k < ADDER_LAT; k++) begin
        tag_vld_q[k] <= tag_vld_q[k-1];
        tag_id_q[k]  <= tag_id_q[k-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Return stage
  // ---------------------------------------------------------------------------
  always_comb begin
    res_vld_d = '0;
    if (tag_vld_q[ADDER_LAT-1]) begin
      res_vld_d[tag_id_q[ADDER_LAT-1]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_vld_q   <= '0;
      res_data_q  <= '0;
      res_state_q <= '0;
    end else begin
      res_vld_q <= res_vld_d;
      // Result bus only updates on a returning op so it holds between pulses.
      if (tag_vld_q[ADDER_LAT-1]) begin
        res_data_q  <= add_result;
        res_state_q <= add_res_state;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_vld   = add_vld_q;
  assign res_vld   = res_vld_q;
  assign res_data  = res_data_q;
  assign res_state = res_state_q;
  assign busy      = add_vld_q | (|tag_vld_q) | (|res_vld_q);

`ifdef FPU_ADD_ARB_PERF_EN
  // ---------------------------------------------------------------------------
  // Performance counters (saturating)
  // ---------------------------------------------------------------------------
  logic [15:0] grant_cnt_q [N_REQ];
  logic [15:0] stall_cnt_q;
  logic        stall_now;

  // Some requester is waiting without a grant this cycle.
  assign stall_now = |(req_vld & ~req_rdy);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        grant_cnt_q[i] <= '0;
      end
    end else begin
      if (stall_now && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (req_rdy[i] && (grant_cnt_q[i] != 16'hFFFF)) begin
          grant_cnt_q[i] <= grant_cnt_q[i] + 16'd1;
        end
      end
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < N_REQ; i++) begin
      grant_cnt[16*i +: 16] = grant_cnt_q[i];
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/fpu_add_arbiter.md
Name: fpu_add_arbiter

Overview:
- Round-robin arbiter that shares one pipelined floating_point_adder among N_REQ requesters.
- Issues at most one operand pair per cycle into the adder.
- Tracks the requester ID of every in-flight operation in a tag shift register matched to the adder latency.
- Routes each result and its res_state back to the originating requester.
- Sits between FPU client blocks and the adder instance; the adder shares its clk/rst.

Parameters:
N_REQ, 4, number of requesters (2..8)
ADDER_LAT, 6, adder latency in cycles from arg_vld sampled to result valid (equals the adder STAGES)
STATE_W, 2, width of the adder res_state (equals the adder WIDTH)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
req_vld  in  N_REQ  per-requester request valid
req_a  in  32*N_REQ  operand A per requester, float_point_num packed {sign,exp[7:0],mant[22:0]}, requester i at bits [32i+31:32i]
req_b  in  32*N_REQ  operand B, same packing
req_rdy  out  N_REQ  one-hot grant, combinational
add_a  out  32  operand A to adder
add_b  out  32  operand B to adder
add_vld  out  1  drives the adder arg_vld
add_result  in  32  adder result
add_res_state  in  STATE_W  adder res_state
res_vld  out  N_REQ  one-hot result pulse
res_data  out  32  result value, shared bus
res_state  out  STATE_W  result status, shared bus
busy  out  1  high while any operation is in flight

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high, sampled on the rising edge.
- Reset values: add_vld=0, add_a=add_b=0, res_vld=0, res_data=0, res_state=0, rr_ptr=0, all tag-pipe valid bits=0, busy=0.
- Arbitration:
  - Search starts at rr_ptr and ascends modulo N_REQ.
  - The first i with req_vld[i]=1 gets req_rdy[i]=1; all other req_rdy bits are 0.
  - req_rdy is all-zero when no req_vld is set.
  - Transfer occurs when req_vld[i] & req_rdy[i] at a clock edge.
  - On a transfer, rr_ptr <= (i+1) mod N_REQ; otherwise rr_ptr holds.
- Requester rule: once req_vld is raised, req_a/req_b stay stable until the transfer. No backpressure on results; a requester must accept res_vld in any cycle.
- Issue stage (registered): on a transfer in cycle h, add_a/add_b/add_vld carry the operands in cycle h+1. add_vld=0 in cycles without a transfer.
- Tag pipeline:
  - ADDER_LAT entries of {valid, id[$clog2(N_REQ)-1:0]}, shifted every cycle.
  - Entry 0 loads {add_vld, issued id}.
  - The output entry aligns with add_result valid in cycle h+1+ADDER_LAT.
- Return stage (registered):
  - When the output entry is valid: res_vld[id]=1 for one cycle in h+2+ADDER_LAT, with res_data=add_result and res_state=add_res_state captured.
  - When not valid: res_vld=0, and res_data/res_state hold their previous values.
- Total latency from handshake to res_vld is ADDER_LAT+2 cycles (8 at the default). Throughput is 1 op/cycle.
- Ordering: results return in issue order; each requester sees its own results in its own request order.
- busy = add_vld | OR of all tag valid bits | any res_vld.
- Simultaneous events: a new grant and a result return in the same cycle are independent; both proceed.
- Reset mid-operation: all in-flight ops are discarded and no res_vld is produced for them. The first res_vld after rst deassertion belongs to a post-reset request.
- Invalid packing or the res_state encoding is passed through untouched; the arbiter never inspects operand values.

Optional Feature:
- Macro: FPU_ADD_ARB_PERF_EN.
- When defined, adds output ports:
  - grant_cnt: 16*N_REQ, per-requester 16-bit saturating count of transfers.
  - stall_cnt: 16, saturating count of cycles where some req_vld[i]=1 and req_rdy[i]=0.
  - All counters clear on rst and saturate at 16'hFFFF.
- When undefined, these ports and counters do not exist and the remaining behaviour is identical.

Test Plan:
- Single op: requester 0 sends a=0x3F800000 (1.0), b=0x40000000 (2.0) with an adder model of latency 6 -> res_vld=4'b0001 exactly 8 cycles after the handshake, res_data=0x40400000 (3.0), res_state passed through.
- Fairness: all 4 req_vld held high for 8 cycles after reset -> grant order 0,1,2,3,0,1,2,3, add_vld high every cycle, results return in the same order back-to-back.
- Pointer skip: rr_ptr=1 with only req_vld[3] and req_vld[0] high -> requester 3 is granted first, then 0, and rr_ptr=1 afterwards.
- Idle gaps: requester 2 sends 0x3F8F5C29 (1.12) + 0x4094CCCD (4.65), idles 3 cycles, then sends again -> two isolated res_vld[2] pulses 4 cycles apart, res_data=0x40B8A3D7 (5.77) each time; busy drops 1 cycle after the last pulse.
- Reset mid-flight: 3 ops issued, rst asserted for 1 cycle 4 cycles later -> no res_vld for those ops; a post-reset op on requester 1 returns after 8 cycles correctly.
- Perf (macro on): requester 0 held for 5 transfers while requester 1 is waiting -> grant_cnt[0]/[1] match the transfer counts and stall_cnt counts the waiting cycles; the counters also saturate when forced near 0xFFFF.
